// File: rtl/usr_pkg.sv
// usr_pkg: shared definitions for the usr command sequencer.
//   op_e    - command opcodes carried on cmd_op (110/111 are illegal)
//   SEL_*   - mode-select encodings understood by the usr register
//   state_e - sequencer FSM states
package usr_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101
  } op_e;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/usr_ctrl_if.sv
// usr_ctrl_if: host-side command handshake and completion status.
//   master modport - host: drives cmd_valid/op/cnt/data, sees ready and status
//   slave modport  - sequencer: the reverse
interface usr_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_data;
  logic             busy;
  logic             done;
  logic             cmd_err;
  logic [WIDTH-1:0] result;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_data,
    input  cmd_ready, busy, done, cmd_err, result
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_data,
    output cmd_ready, busy, done, cmd_err, result
  );
endinterface

// File: rtl/usr.sv
// usr: universal shift register.
//   clk     - rising-edge clock
//   sel     - 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   ip      - parallel load data
//   left_s  - bit entering the LSB on a left shift
//   right_s - bit entering the MSB on a right shift
//   q       - register contents
// There is deliberately no reset: the contents survive a sequencer reset.
module usr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] ip,
  input  logic             left_s,
  input  logic             right_s,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    case (sel)
      2'b01:   q <= {right_s, q[WIDTH-1:1]};
      2'b10:   q <= {q[WIDTH-2:0], left_s};
      2'b11:   q <= ip;
      default: q <= q;
    endcase
  end
endmodule

// File: rtl/usr_ctrl.sv
// usr_ctrl: command sequencer for a single usr instance.
//   clk, rst_n   - clock; synchronous active-low reset
//   cmd          - command handshake and status (usr_ctrl_if slave)
//   ser_in       - serial fill bit for SHL/SHR
//   usr_q        - current usr contents
//   usr_sel      - usr mode select (registered)
//   usr_ip       - usr parallel data (registered)
//   usr_left_s   - bit entering usr LSB on left shift (combinational)
//   usr_right_s  - bit entering usr MSB on right shift (combinational)
//   ser_out      - bit leaving usr on the current shift (combinational)
module usr_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  usr_ctrl_if.slave        cmd,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       usr_sel,
  output logic [WIDTH-1:0] usr_ip,
  output logic             usr_left_s,
  output logic             usr_right_s,
  output logic             ser_out
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] ip_q, ip_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] usr_nxt;
  logic             left_mode, right_mode;

  // Serial lines only matter while a shift is being applied.
  assign left_mode   = (state_q == ST_SHIFT) && (op_q == OP_SHL || op_q == OP_ROL);
  assign right_mode  = (state_q == ST_SHIFT) && (op_q == OP_SHR || op_q == OP_ROR);
  assign usr_left_s  = left_mode  ? ((op_q == OP_ROL) ? usr_q[WIDTH-1] : ser_in) : 1'b0;
  assign usr_right_s = right_mode ? ((op_q == OP_ROR) ? usr_q[0]       : ser_in) : 1'b0;
  assign ser_out     = left_mode ? usr_q[WIDTH-1] : (right_mode ? usr_q[0] : 1'b0);

  // The value usr will hold after this edge. result is captured from this on
  // the edge entering DONE so it is already valid while done is high.
  always_comb begin
    case (sel_q)
      SEL_SHR:  usr_nxt = {usr_right_s, usr_q[WIDTH-1:1]};
      SEL_SHL:  usr_nxt = {usr_q[WIDTH-2:0], usr_left_s};
      SEL_LOAD: usr_nxt = ip_q;
      default:  usr_nxt = usr_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    ip_d     = ip_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d   = cmd.cmd_op;
          cnt_d  = cmd.cmd_cnt;
          ip_d   = cmd.cmd_data;
          busy_d = 1'b1;
          case (cmd.cmd_op)
            OP_LOAD: begin
              state_d = ST_LOAD;
              sel_d   = SEL_LOAD;
            end
            OP_SHL, OP_ROL, OP_SHR, OP_ROR: begin
              if (cmd.cmd_cnt != '0) begin
                state_d = ST_SHIFT;
                sel_d   = (cmd.cmd_op == OP_SHL || cmd.cmd_op == OP_ROL) ? SEL_SHL : SEL_SHR;
              end else begin
                state_d  = ST_DONE;
                done_d   = 1'b1;
                result_d = usr_nxt;
              end
            end
            OP_NOP: begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              result_d = usr_nxt;
            end
            default: begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              err_d    = 1'b1;
              result_d = usr_nxt;
            end
          endcase
        end
      end
      ST_LOAD: begin
        state_d  = ST_DONE;
        sel_d    = SEL_HOLD;
        done_d   = 1'b1;
        result_d = usr_nxt;
      end
      ST_SHIFT: begin
        // cnt_q holds the steps remaining including the current one.
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_DONE;
          sel_d    = SEL_HOLD;
          done_d   = 1'b1;
          result_d = usr_nxt;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      sel_q    <= SEL_HOLD;
      ip_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      ip_q     <= ip_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign cmd.busy      = busy_q;
  assign cmd.done      = done_q;
  assign cmd.cmd_err   = err_q;
  assign cmd.result    = result_q;
  assign usr_sel       = sel_q;
  assign usr_ip        = ip_q;

endmodule

// File: tb/tb_usr_ctrl.sv
// tb_usr_ctrl: directed test of usr_ctrl driving a usr instance.
module tb_usr_ctrl;
  import usr_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             ser_in = 1'b0;
  logic [WIDTH-1:0] usr_q;
  logic [WIDTH-1:0] usr_ip;
  logic [1:0]       usr_sel;
  logic             usr_left_s, usr_right_s, ser_out;
  int               n_cmp = 0;
  int               n_bad = 0;

  usr_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cif ();

  usr_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cif.slave),
    .ser_in     (ser_in),
    .usr_q      (usr_q),
    .usr_sel    (usr_sel),
    .usr_ip     (usr_ip),
    .usr_left_s (usr_left_s),
    .usr_right_s(usr_right_s),
    .ser_out    (ser_out)
  );

  usr #(.WIDTH(WIDTH)) u_usr (
    .clk    (clk),
    .sel    (usr_sel),
    .ip     (usr_ip),
    .left_s (usr_left_s),
    .right_s(usr_right_s),
    .q      (usr_q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data,
                     input logic sin);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_cnt   = cnt;
    cif.cmd_data  = data;
    ser_in        = sin;
    $display("cmd op=%b cnt=%0d data=%b ser_in=%b at %0t", op, cnt, data, sin, $time);
  endtask

  // Called in cycle k+1; returns in the cycle where done is high.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat = 1;
    while (!cif.done && lat < 40) begin
      tick();
      lat++;
    end
    chk(tag, 32'(lat), 32'(exp_lat));
    $display("done %s latency=%0d result=%b err=%b", tag, lat, cif.result, cif.cmd_err);
  endtask

  initial begin
    int done_seen;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = '0;
    cif.cmd_cnt   = '0;
    cif.cmd_data  = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_ready",  32'(cif.cmd_ready), 1);
    chk("rst_busy",   32'(cif.busy),      0);
    chk("rst_done",   32'(cif.done),      0);
    chk("rst_err",    32'(cif.cmd_err),   0);
    chk("rst_sel",    32'(usr_sel),       0);
    chk("rst_ip",     32'(usr_ip),        0);
    chk("rst_result", 32'(cif.result),    0);
    rst_n = 1'b1;
    tick();

    // LOAD 1010
    put(OP_LOAD, 3'd0, 4'b1010, 1'b0);
    chk("ld_ready_k", 32'(cif.cmd_ready), 1);
    tick();
    cif.cmd_valid = 1'b0;
    chk("ld_sel_k1",   32'(usr_sel),       3);
    chk("ld_ip_k1",    32'(usr_ip),        'hA);
    chk("ld_busy_k1",  32'(cif.busy),      1);
    chk("ld_done_k1",  32'(cif.done),      0);
    chk("ld_ready_k1", 32'(cif.cmd_ready), 0);
    tick();
    chk("ld_done_k2",   32'(cif.done),   1);
    chk("ld_result_k2", 32'(cif.result), 'hA);
    chk("ld_sel_k2",    32'(usr_sel),    0);
    chk("ld_busy_k2",   32'(cif.busy),   1);
    chk("ld_q_k2",      32'(usr_q),      'hA);
    tick();
    chk("ld_done_k3",  32'(cif.done),      0);
    chk("ld_busy_k3",  32'(cif.busy),      0);
    chk("ld_ready_k3", 32'(cif.cmd_ready), 1);

    // ROL by 1 then ROR by 4
    put(OP_ROL, 3'd1, 4'b0000, 1'b0);
    tick();
    cif.cmd_valid = 1'b0;
    chk("rol1_sel", 32'(usr_sel), 2);
    wait_done("rol1_lat", 2);
    chk("rol1_result", 32'(cif.result), 'h5);
    tick();
    put(OP_ROR, 3'd4, 4'b0000, 1'b0);
    tick();
    cif.cmd_valid = 1'b0;
    chk("ror4_sel", 32'(usr_sel), 1);
    wait_done("ror4_lat", 5);
    chk("ror4_result", 32'(cif.result),  'h5);
    chk("ror4_err",    32'(cif.cmd_err), 0);
    tick();

    // LOAD 1111 then SHR by 3 with ser_in=0
    put(OP_LOAD, 3'd0, 4'b1111, 1'b0);
    tick();
    cif.cmd_valid = 1'b0;
    wait_done("ld_f_lat", 2);
    chk("ld_f_result", 32'(cif.result), 'hF);
    tick();
    put(OP_SHR, 3'd3, 4'b0000, 1'b0);
    tick();
    cif.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("shr3_sel_%0d", i),     32'(usr_sel),     1);
      chk($sformatf("shr3_serout_%0d", i),  32'(ser_out),     1);
      chk($sformatf("shr3_rights_%0d", i),  32'(usr_right_s), 0);
      chk($sformatf("shr3_done_%0d", i),    32'(cif.done),    0);
      if (i < 2) tick();
    end
    tick();
    chk("shr3_done_k4",   32'(cif.done),   1);
    chk("shr3_result_k4", 32'(cif.result), 'h1);
    chk("shr3_serout_k4", 32'(ser_out),    0);
    tick();

    // SHL with cnt=0, then illegal opcode 111
    put(OP_SHL, 3'd0, 4'b0000, 1'b1);
    tick();
    cif.cmd_valid = 1'b0;
    chk("shl0_done", 32'(cif.done),    1);
    chk("shl0_err",  32'(cif.cmd_err), 0);
    chk("shl0_sel",  32'(usr_sel),     0);
    chk("shl0_q",    32'(usr_q),       'h1);
    tick();
    put(3'b111, 3'd2, 4'b1100, 1'b1);
    tick();
    cif.cmd_valid = 1'b0;
    chk("ill_done",   32'(cif.done),    1);
    chk("ill_err",    32'(cif.cmd_err), 1);
    chk("ill_q",      32'(usr_q),       'h1);
    chk("ill_result", 32'(cif.result),  'h1);
    tick();
    chk("ill_err_after",  32'(cif.cmd_err), 0);
    chk("ill_done_after", 32'(cif.done),    0);

    // Reset during the second cycle of SHL by 5 (ser_in=1)
    put(OP_SHL, 3'd5, 4'b0000, 1'b1);
    tick();
    cif.cmd_valid = 1'b0;
    chk("rstmid_sel_k1", 32'(usr_sel), 2);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rstmid_ready", 32'(cif.cmd_ready), 1);
    chk("rstmid_sel",   32'(usr_sel),       0);
    chk("rstmid_busy",  32'(cif.busy),      0);
    chk("rstmid_q",     32'(usr_q),         'h7);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (cif.done) done_seen++;
      tick();
    end
    chk("rstmid_no_done", 32'(done_seen), 0);
    chk("rstmid_q_held",  32'(usr_q),     'h7);

    // cmd_valid held high: LOAD 0011 then ROL by 7
    put(OP_LOAD, 3'd0, 4'b0011, 1'b0);
    tick();
    put(OP_ROL, 3'd7, 4'b1111, 1'b0);
    chk("b2b_ready_k1", 32'(cif.cmd_ready), 0);
    tick();
    chk("b2b_done_k2",   32'(cif.done),      1);
    chk("b2b_result_k2", 32'(cif.result),    'h3);
    chk("b2b_ready_k2",  32'(cif.cmd_ready), 0);
    tick();
    chk("b2b_ready_k3", 32'(cif.cmd_ready), 1);
    tick();
    cif.cmd_valid = 1'b0;
    chk("b2b_busy",  32'(cif.busy), 1);
    chk("b2b_sel",   32'(usr_sel),  2);
    wait_done("b2b_rol7_lat", 8);
    chk("b2b_result", 32'(cif.result), 'h9);
    tick();
    chk("b2b_idle", 32'(cif.cmd_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
